dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter sharing the single-port data memory between the CPU load/store port (port 0) and a loader/debug port (port 1). Performs per-cycle arbitration, supports a bounded lock for loader bursts, drives the memory port, and returns registered read data to the winning requester. Sits between `cpu` / loader and `data_mem` in the top level.

## Interface
Parameters:
- ADDR_WIDTH, 32, requester address width (byte address)
- DATA_WIDTH, 32, data width
- MEM_AW, 15, memory address width; `mem_addr = addr[MEM_AW-1:0]`
- LOCK_MAX, 16, max consecutive cycles a lock may hold the memory (≥2)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- p0_req / p1_req  in  1  request this cycle
- p0_we / p1_we  in  1  1 = write, 0 = read
- p0_wmask / p1_wmask  in  4  byte write mask
- p0_addr / p1_addr  in  ADDR_WIDTH  byte address
- p0_wdata / p1_wdata  in  DATA_WIDTH  write data
- p0_lock / p1_lock  in  1  hold grant across cycles
- p0_gnt / p1_gnt  out  1  combinational grant, same cycle as req
- p0_stall  out  1  `p0_req & ~p0_gnt`
- p0_rvalid / p1_rvalid  out  1  read data valid, registered
- p0_rdata / p1_rdata  out  DATA_WIDTH  registered read data
- mem_addr  out  MEM_AW  to data memory
- mem_wdata  out  DATA_WIDTH  to data memory
- mem_wmask  out  4  to data memory
- mem_we  out  1  write enable to data memory
- mem_rdata  in  DATA_WIDTH  combinational read data from data memory

## Operation
- At most one of p0_gnt/p1_gnt high per cycle; a grant occurs only when the matching req is high.
- Memory mux: granted port's addr/wdata/wmask/we drive the memory; no grant → mem_we=0, mem_wmask=0, mem_addr=0, mem_wdata=0.
- Read response: on a granted read (`gnt & ~we`), the next cycle that port's rvalid=1 and rdata=mem_rdata sampled at the grant cycle. rdata holds its value until the next granted read of that port; rvalid is a one-cycle pulse.
- Writes produce no rvalid.
- State machine (`state`): IDLE, LOCK0, LOCK1.
  - IDLE: arbitrate (see Configuration). If the winner has lock=1 → LOCKn, lock counter cleared.
  - LOCKn: only port n may be granted (other port stalls even if n is idle). Counter increments every cycle in LOCKn. lock_n=0 → IDLE next cycle (the cycle lock drops is still owned by n). Counter reaches LOCK_MAX-1 → forced to IDLE next cycle, `last_gnt` set to n so the other port wins the next contention.
- `last_gnt` (1 bit) updated to the granted port on every grant.
- Reset: state=IDLE, counter=0, last_gnt=1 (port 0 wins first tie), rvalid=0, rdata=0, grants combinationally low during reset.

## Timing
- Grant: 0 cycles (combinational from req, state, last_gnt).
- Write: committed by data memory at the edge ending the grant cycle.
- Read: rvalid/rdata 1 cycle after grant.
- Back-to-back grants to the same port every cycle allowed; throughput 1 transaction/cycle.
- Simultaneous req in IDLE: resolved per Configuration; loser's stall/gnt=0 in that cycle, retried next cycle by holding req.
- Lock request from the loser of contention is ignored (no state change).
- rst asserted mid-lock or with a read in flight: next cycle state=IDLE, rvalid=0; pending read data discarded.
- Lock held LOCK_MAX cycles: exactly LOCK_MAX consecutive owned cycles, then IDLE.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin in IDLE — on contention the port ≠ last_gnt wins.
- Not defined: fixed priority, port 0 always wins contention in IDLE; last_gnt still maintained for the forced-unlock rule, but ignored in IDLE arbitration. Locks behave identically in both builds.

## Test plan
- Reset, then p0 read addr 0x10 with memory word 0xDEADBEEF → p0_gnt=1 same cycle, next cycle p0_rvalid=1, p0_rdata=0xDEADBEEF; p1 outputs stay 0.
- Both req every cycle, no lock, RR build → grants alternate p0,p1,p0,...; fixed build → p0 every cycle, p1_gnt never 1.
- p1 writes 0x12345678 to 0x20 wmask 4'b0011 with p1_lock=1 for 5 cycles while p0 requests → p0_stall=1 for 5 cycles, then p0 granted; mem_we/mem_wmask match p1 during lock.
- p1_lock held 40 cycles, LOCK_MAX=16 → p1 owns exactly 16 cycles, then p0 granted next contention cycle.
- rst pulsed during LOCK1 with a p1 read granted the same cycle → after reset state IDLE, p1_rvalid=0, p0 wins first contention.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory (port 0 = CPU, port 1 = loader/debug).
// Define DMEM_ARB_RR_EN for round-robin contention; default build is fixed priority to port 0.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_AW     = 15,
  parameter int LOCK_MAX   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [3:0]            p0_wmask,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  input  logic                  p0_lock,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [3:0]            p1_wmask,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  input  logic                  p1_lock,
  output logic                  p0_gnt,
  output logic                  p1_gnt,
  output logic                  p0_stall,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wmask,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOCK0 = 2'd1;
  localparam logic [1:0] LOCK1 = 2'd2;

  localparam int CNT_W = $clog2(LOCK_MAX);
  // The granting IDLE cycle is the first owned cycle, so the lock ends when the
  // in-lock counter would reach LOCK_MAX-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 2);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             last_gnt, last_gnt_nxt;
  logic             p0_wins_tie;
  logic             unused_addr_bits;

`ifdef DMEM_ARB_RR_EN
  assign p0_wins_tie = last_gnt;
`else
  assign p0_wins_tie = 1'b1;
`endif

  assign unused_addr_bits = ^{p0_addr[ADDR_WIDTH-1:MEM_AW], p1_addr[ADDR_WIDTH-1:MEM_AW]};

  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!rst) begin
      case (state)
        LOCK0:   p0_gnt = p0_req;
        LOCK1:   p1_gnt = p1_req;
        default: begin
          if (p0_req && p1_req) begin
            p0_gnt = p0_wins_tie;
            p1_gnt = ~p0_wins_tie;
          end else begin
            p0_gnt = p0_req;
            p1_gnt = p1_req;
          end
        end
      endcase
    end
  end

  assign p0_stall = p0_req & ~p0_gnt;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    mem_we    = 1'b0;
    if (p0_gnt) begin
      mem_addr  = p0_addr[MEM_AW-1:0];
      mem_wdata = p0_wdata;
      mem_wmask = p0_wmask;
      mem_we    = p0_we;
    end else if (p1_gnt) begin
      mem_addr  = p1_addr[MEM_AW-1:0];
      mem_wdata = p1_wdata;
      mem_wmask = p1_wmask;
      mem_we    = p1_we;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    last_gnt_nxt = last_gnt;
    if (p0_gnt)      last_gnt_nxt = 1'b0;
    else if (p1_gnt) last_gnt_nxt = 1'b1;
    case (state)
      IDLE: begin
        if (p0_gnt && p0_lock) begin
          state_nxt = LOCK0;
          cnt_nxt   = '0;
        end else if (p1_gnt && p1_lock) begin
          state_nxt = LOCK1;
          cnt_nxt   = '0;
        end
      end
      LOCK0: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (!p0_lock) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt    = IDLE;
          last_gnt_nxt = 1'b0;
        end
      end
      LOCK1: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (!p1_lock) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt    = IDLE;
          last_gnt_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  // Read response stage: data sampled in the grant cycle, presented the next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      p0_rvalid <= p0_gnt & ~p0_we;
      p1_rvalid <= p1_gnt & ~p1_we;
      if (p0_gnt && !p0_we) p0_rdata <= mem_rdata;
      if (p1_gnt && !p1_we) p1_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a read-response scoreboard and a small word memory.
module tb_dmem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAW  = 15;
  localparam int LMAX = 16;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic p0_req, p0_we, p0_lock, p1_req, p1_we, p1_lock;
  logic [3:0] p0_wmask, p1_wmask, mem_wmask;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, mem_wdata, mem_rdata;
  logic p0_gnt, p1_gnt, p0_stall, p0_rvalid, p1_rvalid, mem_we;
  logic [MAW-1:0] mem_addr;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_AW(MAW), .LOCK_MAX(LMAX)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_wmask(p0_wmask), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_lock(p0_lock),
    .p1_req(p1_req), .p1_we(p1_we), .p1_wmask(p1_wmask), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_lock(p1_lock),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_stall(p0_stall),
    .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(int i);
    if (i == 4) return 32'hDEAD_BEEF;
    return 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  // Word memory: combinational read, byte-masked write at the clock edge
  logic mem_init;
  logic [31:0] mem [64];
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  typedef struct packed { logic port; logic [31:0] data; } rd_t;
  rd_t sb[$];
  logic [31:0] ref_mem [64];
  logic [31:0] last_rd0, last_rd1;
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    for (int b = 0; b < 4; b++)
      if (m[b]) ref_mem[a[7:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic drv0(input logic r, input logic w, input logic l, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] m);
    p0_req = r; p0_we = w; p0_lock = l; p0_addr = a; p0_wdata = d; p0_wmask = m;
  endtask

  task automatic drv1(input logic r, input logic w, input logic l, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] m);
    p1_req = r; p1_we = w; p1_lock = l; p1_addr = a; p1_wdata = d; p1_wmask = m;
  endtask

  // One clock: check grants/mux mid-cycle, then the registered response after the edge
  task automatic step(input logic eg0, input logic eg1);
    rd_t e;
    logic ev0, ev1;
    @(negedge clk);
    chk("p0_gnt", p0_gnt, eg0);
    chk("p1_gnt", p1_gnt, eg1);
    chk("p0_stall", p0_stall, p0_req & ~eg0);
    if (eg0) begin
      chk("mem_addr_p0", mem_addr, p0_addr[MAW-1:0]);
      chk("mem_we_p0", mem_we, p0_we);
      if (p0_we) begin
        chk("mem_wmask_p0", mem_wmask, p0_wmask);
        chk("mem_wdata_p0", mem_wdata, p0_wdata);
        ref_write(p0_addr, p0_wdata, p0_wmask);
      end else sb.push_back(rd_t'{port: 1'b0, data: ref_mem[p0_addr[7:2]]});
    end else if (eg1) begin
      chk("mem_addr_p1", mem_addr, p1_addr[MAW-1:0]);
      chk("mem_we_p1", mem_we, p1_we);
      if (p1_we) begin
        chk("mem_wmask_p1", mem_wmask, p1_wmask);
        chk("mem_wdata_p1", mem_wdata, p1_wdata);
        ref_write(p1_addr, p1_wdata, p1_wmask);
      end else sb.push_back(rd_t'{port: 1'b1, data: ref_mem[p1_addr[7:2]]});
    end else begin
      chk("mem_we_idle", mem_we, 1'b0);
      chk("mem_wmask_idle", mem_wmask, 4'b0);
      chk("mem_addr_idle", mem_addr, '0);
    end
    @(posedge clk);
    #1;
    ev0 = 1'b0;
    ev1 = 1'b0;
    if (rst) begin
      sb.delete();
      last_rd0 = '0;
      last_rd1 = '0;
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.port) begin ev1 = 1'b1; last_rd1 = e.data; end
      else        begin ev0 = 1'b1; last_rd0 = e.data; end
    end
    chk("p0_rvalid", p0_rvalid, ev0);
    chk("p1_rvalid", p1_rvalid, ev1);
    chk("p0_rdata", p0_rdata, last_rd0);
    chk("p1_rdata", p1_rdata, last_rd1);
  endtask

  initial begin
    logic e0, e1;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    last_rd0 = '0;
    last_rd1 = '0;
    rst = 1'b1;
    mem_init = 1'b1;
    drv0(0, 0, 0, 0, 0, 0);
    drv1(0, 0, 0, 0, 0, 0);

    // Reset: outputs cleared, grants held low even with requests pending
    step(0, 0);
    drv0(1, 0, 0, 32'h10, 0, 0);
    drv1(1, 0, 0, 32'h08, 0, 0);
    step(0, 0);

    rst = 1'b0;
    mem_init = 1'b0;
    drv1(0, 0, 0, 0, 0, 0);
    step(1, 0);
    drv0(0, 0, 0, 0, 0, 0);
    step(0, 0);

    // Contention without lock
    for (int i = 0; i < 4; i++) begin
      drv0(1, 0, 0, 32'h04, 0, 0);
      drv1(1, 0, 0, 32'h08, 0, 0);
      e0 = RR ? (i % 2 == 1) : 1'b1;
      step(e0, ~e0);
    end

    // Locked p1 write burst; p0 stalls for five cycles
    drv0(0, 0, 0, 0, 0, 0);
    drv1(1, 1, 1, 32'h20, 32'h1234_5678, 4'b0011);
    step(0, 1);
    drv0(1, 0, 0, 32'h10, 0, 0);
    step(0, 1);
    step(0, 1);
    drv1(0, 0, 1, 32'h20, 32'h1234_5678, 4'b0011);
    step(0, 0);
    drv1(1, 1, 1, 32'h20, 32'h1234_5678, 4'b0011);
    step(0, 1);
    drv1(1, 1, 0, 32'h20, 32'h1234_5678, 4'b0011);
    step(0, 1);
    drv1(0, 0, 0, 0, 0, 0);
    drv0(1, 0, 0, 32'h20, 0, 0);
    step(1, 0);

    // Lock held 40 cycles against a contending p0
    for (int i = 0; i < 40; i++) begin
      drv1(1, 0, 1, 32'h08, 0, 0);
      drv0(i > 0, 0, 0, 32'h0C, 0, 0);
      e1 = RR ? ((i % (LMAX + 1)) < LMAX) : (i < LMAX);
      e0 = (i > 0) && !e1;
      step(e0, e1);
    end
    drv0(0, 0, 0, 0, 0, 0);
    drv1(0, 0, 0, 0, 0, 0);
    step(0, 0);

    // Reset during a lock with a p1 read outstanding
    drv1(1, 0, 1, 32'h08, 0, 0);
    step(0, 1);
    rst = 1'b1;
    drv0(1, 0, 0, 32'h04, 0, 0);
    step(0, 0);
    rst = 1'b0;
    step(1, 0);
    drv0(0, 0, 0, 0, 0, 0);
    drv1(0, 0, 0, 0, 0, 0);
    step(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
